// File: rtl/input_layer_loader_if.sv
// Byte-stream and RAM-write bundle for input_layer_loader.
// master: UART side / sequencer that issues start and pixel bytes.
// slave:  the loader, which drives the RAM write port and status.
interface input_layer_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_vld;
    logic              byte_rdy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_data;
    logic              busy;
    logic              done;
    logic              cksum_err;

    modport master (
        output start, byte_in, byte_vld,
        input  byte_rdy, ram_we, ram_addr, ram_data, busy, done, cksum_err
    );

    modport slave (
        input  start, byte_in, byte_vld,
        output byte_rdy, ram_we, ram_addr, ram_data, busy, done, cksum_err
    );
endinterface

// File: rtl/input_layer_loader.sv
// input_layer_loader: fills the 1-bit input-layer RAM with one image frame.
// Each accepted byte is unpacked LSB-first into 8 consecutive single-bit
// writes; done pulses once NUM_PIXELS bits are stored.
// Optional feature macro: LOADER_CKSUM_EN -- accept a trailer byte after the
// frame and flag cksum_err when it differs from the mod-256 sum of the data.
module input_layer_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input_layer_loader_if.slave bus
);
    localparam int                CNT_W     = ADDR_W - 3;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_PIXELS / 8 - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_UNPACK = 3'd2;
    localparam logic [2:0] S_FIN    = 3'd4;
`ifdef LOADER_CKSUM_EN
    localparam logic [2:0] S_CKSUM  = 3'd3;
`endif

    logic [2:0]        state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [2:0]        bit_cnt;
    logic [6:0]        shreg;      // remaining bits 1..7 of the current byte
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_data_q;
    logic              busy_q;
    logic              done_q;
    logic              byte_rdy;
`ifdef LOADER_CKSUM_EN
    logic [7:0]        sum;
    logic              cksum_err_q;
`endif

    // Ready is a pure function of state so the sender sees it without delay.
`ifdef LOADER_CKSUM_EN
    assign byte_rdy = (state == S_LOAD) || (state == S_CKSUM);
`else
    assign byte_rdy = (state == S_LOAD);
`endif

    assign bus.byte_rdy = byte_rdy;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef LOADER_CKSUM_EN
    assign bus.cksum_err = cksum_err_q;
`else
    assign bus.cksum_err = 1'b0;
`endif

    // Frame FSM: load a byte, then spend 8 cycles writing its bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= BASE;
            ram_data_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LOADER_CKSUM_EN
            sum         <= '0;
            cksum_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_LOAD;
                        busy_q   <= 1'b1;
                        byte_cnt <= '0;
`ifdef LOADER_CKSUM_EN
                        sum         <= '0;
                        cksum_err_q <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    // Bit 0 goes out right away; bits 1..7 wait in shreg.
                    if (bus.byte_vld) begin
                        state      <= S_UNPACK;
                        shreg      <= bus.byte_in[7:1];
                        ram_we_q   <= 1'b1;
                        ram_data_q <= bus.byte_in[0];
                        ram_addr_q <= BASE + {byte_cnt, 3'b000};
                        bit_cnt    <= '0;
`ifdef LOADER_CKSUM_EN
                        sum        <= sum + bus.byte_in;
`endif
                    end
                end
                S_UNPACK: begin
                    if (bit_cnt == 3'd7) begin
                        ram_we_q <= 1'b0;
                        if (byte_cnt == LAST_BYTE) begin
`ifdef LOADER_CKSUM_EN
                            state  <= S_CKSUM;
`else
                            state  <= S_FIN;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= S_LOAD;
                        end
                    end else begin
                        bit_cnt    <= bit_cnt + 3'd1;
                        ram_addr_q <= ram_addr_q + 1'b1;
                        ram_data_q <= shreg[0];
                        shreg      <= {1'b0, shreg[6:1]};
                    end
                end
`ifdef LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (bus.byte_vld) begin
                        cksum_err_q <= (bus.byte_in != sum);
                        state       <= S_FIN;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
`endif
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_layer_loader.sv
// Directed bench for input_layer_loader: frame loads, handshake gaps,
// ignored start/valid, mid-load reset, checksum trailer, back-to-back frames.
module tb_input_layer_loader;
    localparam int NPIX   = 784;
    localparam int NBYTES = NPIX / 8;
`ifdef LOADER_CKSUM_EN
    localparam int NXFER = NBYTES + 1;
`else
    localparam int NXFER = NBYTES;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_layer_loader_if #(.ADDR_W(10)) bus ();

    input_layer_loader #(.NUM_PIXELS(NPIX), .ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    // monitor-owned state: shadow RAM and event counters
    logic mem [0:1023];
    int wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
    int addr_err = 0, rdy_err = 0, busy_err = 0;
    int next_addr = 0;

    always @(negedge clk) begin
        if (bus.start && !bus.busy) next_addr = 0;
        if (bus.ram_we) begin
            mem[bus.ram_addr] = bus.ram_data;
            wr_cnt++;
            if (int'(bus.ram_addr) != next_addr) addr_err++;
            next_addr++;
            if (bus.byte_rdy) rdy_err++;
            if (!bus.busy) busy_err++;
        end
        if (rst_n && bus.byte_vld && bus.byte_rdy) acc_cnt++;
        if (bus.done) begin
            done_cnt++;
            if (bus.busy) busy_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        if (gap) begin
            bus.byte_vld = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        bus.byte_in  = b;
        bus.byte_vld = 1'b1;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (bus.byte_rdy) break;
            k++;
        end
        if (k == 40) chk("rdy_timeout", 0, 1);
        @(posedge clk); #1;
        if (gap) bus.byte_vld = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // full frame: byte 0 = b0, rest = rb; trl[8] overrides the trailer value
    task automatic load_frame(input logic [7:0] b0, input logic [7:0] rb, input bit gap,
                              input int spulse, input logic [8:0] trl);
        logic [7:0] s;
        int d0, k;
        s  = 8'h00;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < NBYTES; i++) begin
            if (i == spulse) begin
                bus.start = 1'b1;
                @(posedge clk); #1 bus.start = 1'b0;
            end
            send_byte((i == 0) ? b0 : rb, gap);
            s = s + ((i == 0) ? b0 : rb);
        end
`ifdef LOADER_CKSUM_EN
        send_byte(trl[8] ? trl[7:0] : s, gap);
`else
        if (trl[8]) s = trl[7:0];
`endif
        bus.byte_vld = 1'b0;
        k = 0;
        while (k < 30 && done_cnt == d0) begin @(negedge clk); k++; end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] b0, input logic [7:0] rb);
        int errs;
        logic [7:0] b;
        errs = 0;
        for (int i = 0; i < NPIX; i++) begin
            b = (i < 8) ? b0 : rb;
            if (mem[i] !== b[i % 8]) errs++;
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        int w0, d0, a0, ae0, re0, ones;
        bus.start = 1'b0; bus.byte_in = 8'h00; bus.byte_vld = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",  bus.byte_rdy, 0);
        chk("rst_we",   bus.ram_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cerr", bus.cksum_err, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_data", bus.ram_data, 0);
        rst_n = 1'b1;

        // 1: A5 frame, valid held high
        w0 = wr_cnt; d0 = done_cnt; ae0 = addr_err;
        load_frame(8'hA5, 8'hA5, 1'b0, -1, 9'h000);
        chk("t1_writes", wr_cnt - w0, NPIX);
        chk("t1_addr_seq", addr_err - ae0, 0);
        chk_mem("t1_data", 8'hA5, 8'hA5);
        @(negedge clk);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_busy_after", bus.busy, 0);
        chk("t1_busy_err", busy_err, 0);

        // 2: 01 then zeros, gapped valid
        w0 = wr_cnt; a0 = acc_cnt; re0 = rdy_err;
        load_frame(8'h01, 8'h00, 1'b1, -1, 9'h000);
        chk("t2_writes", wr_cnt - w0, NPIX);
        chk("t2_accepts", acc_cnt - a0, NXFER);
        chk("t2_rdy_in_unpack", rdy_err - re0, 0);
        chk("t2_addr0", mem[0], 1);
        ones = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] === 1'b1) ones++;
        chk("t2_ones", ones, 1);

        // 3: valid while idle, start while busy
        @(posedge clk); #1;
        w0 = wr_cnt; a0 = acc_cnt;
        bus.byte_in = 8'hFF; bus.byte_vld = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3_idle_writes", wr_cnt - w0, 0);
        chk("t3_idle_accepts", acc_cnt - a0, 0);
        chk("t3_idle_busy", bus.busy, 0);
        chk("t3_idle_rdy", bus.byte_rdy, 0);
        @(posedge clk); #1 bus.byte_vld = 1'b0;
        w0 = wr_cnt; d0 = done_cnt; ae0 = addr_err;
        load_frame(8'h3C, 8'h3C, 1'b0, 10, 9'h000);
        chk("t3_writes", wr_cnt - w0, NPIX);
        chk("t3_addr_seq", addr_err - ae0, 0);
        chk("t3_done_cnt", done_cnt - d0, 1);
        chk_mem("t3_data", 8'h3C, 8'h3C);

        // 4: reset during byte 5, bit 3
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(8'hFF, 1'b0);
        bus.byte_vld = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t4_we_bit3", bus.ram_we, 1);
        chk("t4_addr_bit3", bus.ram_addr, 43);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_we_after", bus.ram_we, 0);
        chk("t4_busy_after", bus.busy, 0);
        chk("t4_addr_after", bus.ram_addr, 0);
        w0 = wr_cnt;
        @(negedge clk);
        chk("t4_no_writes", wr_cnt - w0, 0);
        rst_n = 1'b1;
        w0 = wr_cnt; ae0 = addr_err;
        load_frame(8'h00, 8'h00, 1'b0, -1, 9'h000);
        chk("t4_writes", wr_cnt - w0, NPIX);
        chk("t4_addr_seq", addr_err - ae0, 0);
        chk_mem("t4_data", 8'h00, 8'h00);

`ifdef LOADER_CKSUM_EN
        // 5: checksum trailer good / bad / cleared by start
        load_frame(8'h01, 8'h01, 1'b0, -1, 9'h162);
        @(negedge clk);
        chk("t5_cerr_good", bus.cksum_err, 0);
        load_frame(8'h01, 8'h01, 1'b0, -1, 9'h163);
        @(negedge clk);
        chk("t5_cerr_bad", bus.cksum_err, 1);
        repeat (5) @(negedge clk);
        chk("t5_cerr_hold", bus.cksum_err, 1);
        chk_mem("t5_data", 8'h01, 8'h01);
        pulse_start();
        @(negedge clk);
        chk("t5_cerr_clr", bus.cksum_err, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`else
        chk("t5_cerr_tied", bus.cksum_err, 0);
`endif

        // 6: back-to-back frames
        w0 = wr_cnt; d0 = done_cnt; ae0 = addr_err;
        load_frame(8'h00, 8'h00, 1'b0, -1, 9'h000);
        load_frame(8'hFF, 8'hFF, 1'b0, -1, 9'h000);
        @(negedge clk);
        chk("t6_writes", wr_cnt - w0, 2 * NPIX);
        chk("t6_done_cnt", done_cnt - d0, 2);
        chk("t6_addr_seq", addr_err - ae0, 0);
        chk_mem("t6_data", 8'hFF, 8'hFF);
        chk("t6_busy_err", busy_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
